// File: rtl/mem_arbiter.sv
// mem_arbiter
// Round-robin arbiter and sequencer that lets two hardware threads share one
// single-ported data memory. One request is granted at a time. The memory port
// is strobed for one cycle, the block waits out the read latency, and it then
// returns a one-cycle acknowledge with the captured load data to the winner.
//
// Ports
//   clk, reset            clock; asynchronous active-high reset
//   halt                  blocks new grants; an in-flight transaction completes
//   req0/1, we0/1         per-thread request and store flag (1 = store)
//   addr0/1, wdata0/1     per-thread word address and store data
//   ack0/1                one-cycle completion pulse to the granted thread
//   rdata0/1              per-thread load result, held until that thread's next load
//   mem_en, mem_we        memory strobe and write enable (ISSUE cycle only)
//   mem_addr, mem_wdata   memory address / write data (hold last value)
//   mem_rdata             memory read data
//   busy                  high whenever the FSM is not in IDLE
//   owner                 id of the granted thread, held through the transaction
module mem_arbiter #(
  parameter int LATENCY = 1,
  parameter int DATA_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              halt,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [DATA_W-1:0] addr0,
  input  logic [DATA_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              mem_en,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              owner
);

  localparam logic [2:0] LAT_C = 3'(LATENCY);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t     state;
  logic       prio;
  logic [2:0] count;
  logic       we_lat;

  logic       gnt_any;
  logic       gnt_id;

  // Winner selection: the priority pointer only matters when both request.
  always_comb begin
    gnt_any = req0 | req1;
    gnt_id  = (req0 && req1) ? prio : req1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      prio      <= 1'b0;
      count     <= 3'd0;
      we_lat    <= 1'b0;
      ack0      <= 1'b0;
      ack1      <= 1'b0;
      rdata0    <= '0;
      rdata1    <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      busy      <= 1'b0;
      owner     <= 1'b0;
    end else begin
      case (state)
        // IDLE -> ISSUE: latch the winner's operands straight into the memory
        // port registers so the strobe appears in the very next cycle.
        IDLE: begin
          if (gnt_any && !halt) begin
            state     <= ISSUE;
            owner     <= gnt_id;
            prio      <= ~gnt_id;
            busy      <= 1'b1;
            mem_en    <= 1'b1;
            mem_we    <= gnt_id ? we1 : we0;
            we_lat    <= gnt_id ? we1 : we0;
            mem_addr  <= gnt_id ? addr1 : addr0;
            mem_wdata <= gnt_id ? wdata1 : wdata0;
          end
        end
        // ISSUE -> WAIT: strobe lasts exactly one cycle; address/data hold.
        ISSUE: begin
          mem_en <= 1'b0;
          mem_we <= 1'b0;
          count  <= LAT_C;
          state  <= WAIT;
        end
        // WAIT -> RESP: count==1 marks the cycle in which mem_rdata is valid.
        WAIT: begin
          if (count == 3'd1) begin
            if (!we_lat) begin
              if (owner) rdata1 <= mem_rdata;
              else       rdata0 <= mem_rdata;
            end
            ack0  <= ~owner;
            ack1  <= owner;
            count <= 3'd0;
            state <= RESP;
          end else begin
            count <= count - 3'd1;
          end
        end
        // RESP -> IDLE: acknowledge is a single-cycle pulse.
        RESP: begin
          ack0  <= 1'b0;
          ack1  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  localparam int L = 3;
  localparam int P = L + 3;

  logic        clk = 1'b0;
  logic        reset, halt;
  logic        req0, req1, we0, we1;
  logic [15:0] addr0, addr1, wdata0, wdata1;
  logic        ack0, ack1, mem_en, mem_we, busy, owner;
  logic [15:0] rdata0, rdata1, mem_addr, mem_wdata, mem_rdata;

  mem_arbiter #(.LATENCY(L), .DATA_W(16)) dut (
    .clk(clk), .reset(reset), .halt(halt),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy), .owner(owner)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: power-on contents come from init_word, stores overlay them.
  // Read data is valid only in the L-th cycle after the strobe, otherwise 0xDEAD.
  logic [15:0]  mem [256];
  logic [255:0] wr_v;
  logic [7:0]   rd_a;
  int           rd_cnt = 0;

  function automatic logic [15:0] init_word(input logic [7:0] a);
    case (a)
      8'h10:   return 16'h1234;
      8'h01:   return 16'h1111;
      8'h02:   return 16'h2222;
      default: return {8'hC0, a};
    endcase
  endfunction

  always @(posedge clk) begin
    if (reset) wr_v <= '0;
    if (mem_en) begin
      rd_a   <= mem_addr[7:0];
      rd_cnt <= 1;
      if (mem_we) begin
        mem[mem_addr[7:0]]  <= mem_wdata;
        wr_v[mem_addr[7:0]] <= 1'b1;
      end
    end else if (rd_cnt != 0 && rd_cnt < 15) begin
      rd_cnt <= rd_cnt + 1;
    end
  end

  assign mem_rdata = (rd_cnt == L) ? (wr_v[rd_a] ? mem[rd_a] : init_word(rd_a)) : 16'hDEAD;

  // Scoreboard
  typedef struct { int cyc; logic we; logic [15:0] addr; logic [15:0] wdata; } mem_e_t;
  typedef struct { int cyc; int id; logic [15:0] rdata; } ack_e_t;
  mem_e_t exp_mem [$];
  ack_e_t exp_ack [$];
  mem_e_t m_got;
  ack_e_t a_got;

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic bad(input string name, input int at);
    n_total++;
    $display("FAIL %s: event at cycle %0d, expected none", name, at);
  endtask

  task automatic push_mem(input int c, input logic we, input logic [15:0] a, input logic [15:0] d);
    mem_e_t e;
    e.cyc = c; e.we = we; e.addr = a; e.wdata = d;
    exp_mem.push_back(e);
  endtask

  task automatic push_ack(input int c, input int id, input logic [15:0] r);
    ack_e_t e;
    e.cyc = c; e.id = id; e.rdata = r;
    exp_ack.push_back(e);
  endtask

  // Monitor
  always @(negedge clk) begin
    if (mem_en) begin
      if (exp_mem.size() == 0) bad("mem_en_unexpected", cyc);
      else begin
        m_got = exp_mem.pop_front();
        chk("mem_cycle", 32'(cyc), 32'(m_got.cyc));
        chk("mem_we", 32'(mem_we), 32'(m_got.we));
        chk("mem_addr", 32'(mem_addr), 32'(m_got.addr));
        chk("mem_wdata", 32'(mem_wdata), 32'(m_got.wdata));
      end
    end
    if (ack0 || ack1) begin
      if (exp_ack.size() == 0) bad("ack_unexpected", cyc);
      else begin
        a_got = exp_ack.pop_front();
        chk("ack_cycle", 32'(cyc), 32'(a_got.cyc));
        chk("ack_pair", 32'({ack1, ack0}), (a_got.id == 1) ? 32'd2 : 32'd1);
        chk("ack_rdata", 32'((a_got.id == 1) ? rdata1 : rdata0), 32'(a_got.rdata));
        chk("ack_owner", 32'(owner), 32'(a_got.id));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic raise(input int id, input logic we, input logic [15:0] a, input logic [15:0] d);
    if (id == 0) begin req0 = 1'b1; we0 = we; addr0 = a; wdata0 = d; end
    else         begin req1 = 1'b1; we1 = we; addr1 = a; wdata1 = d; end
  endtask

  // Hold request until the ack cycle, drop it the cycle after, idle one more.
  task automatic wait_ack(input int id);
    int  waited = 0;
    bit  got = 0;
    while (!got && waited < 200) begin
      @(negedge clk);
      waited++;
      got = (id == 0) ? ack0 : ack1;
    end
    if (!got) begin
      n_total++;
      $display("FAIL ack_timeout: thread %0d got no ack, expected one within 200 cycles", id);
    end
    tick(1);
    if (id == 0) req0 = 1'b0; else req1 = 1'b0;
    tick(1);
  endtask

  task automatic txn(input int id, input logic we, input logic [15:0] a, input logic [15:0] d);
    raise(id, we, a, d);
    wait_ack(id);
  endtask

  task automatic seq3(input int id, input logic [15:0] base);
    for (int j = 0; j < 3; j++) txn(id, 1'b0, base + 16'(j), 16'h0000);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_ack0"}, 32'(ack0), 32'd0);
    chk({tag, "_ack1"}, 32'(ack1), 32'd0);
    chk({tag, "_rdata0"}, 32'(rdata0), 32'd0);
    chk({tag, "_rdata1"}, 32'(rdata1), 32'd0);
    chk({tag, "_mem_en"}, 32'(mem_en), 32'd0);
    chk({tag, "_mem_we"}, 32'(mem_we), 32'd0);
    chk({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    chk({tag, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_owner"}, 32'(owner), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at 200000, expected finish earlier");
    $fatal(1, "watchdog");
  end

  int T, H;

  initial begin
    reset = 1'b1; halt = 1'b0;
    req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    tick(3);
    chk_reset("rst");
    reset = 1'b0;
    tick(2);

    // Both threads load at once: thread 0 first (prio=0), then thread 1.
    T = cyc;
    push_mem(T + 1, 1'b0, 16'h0001, 16'h0000);
    push_mem(T + 4 + L, 1'b0, 16'h0002, 16'h0000);
    push_ack(T + 2 + L, 0, 16'h1111);
    push_ack(T + 5 + 2 * L, 1, 16'h2222);
    fork
      txn(0, 1'b0, 16'h0001, 16'h0000);
      txn(1, 1'b0, 16'h0002, 16'h0000);
    join

    // Single load by thread 0.
    T = cyc;
    push_mem(T + 1, 1'b0, 16'h0010, 16'h0000);
    push_ack(T + 2 + L, 0, 16'h1234);
    txn(0, 1'b0, 16'h0010, 16'h0000);

    // Thread 1 store, then load back; the store leaves rdata1 at 0x2222.
    T = cyc;
    push_mem(T + 1, 1'b1, 16'h0005, 16'h00AA);
    push_ack(T + 2 + L, 1, 16'h2222);
    txn(1, 1'b1, 16'h0005, 16'h00AA);
    T = cyc;
    push_mem(T + 1, 1'b0, 16'h0005, 16'h0000);
    push_ack(T + 2 + L, 1, 16'h00AA);
    txn(1, 1'b0, 16'h0005, 16'h0000);

    // Continuous traffic: six grants alternating 0,1,..., one every P cycles.
    T = cyc;
    for (int k = 0; k < 6; k++) begin
      logic [15:0] a;
      a = (k % 2 == 1) ? 16'(16'h0030 + k / 2) : 16'(16'h0020 + k / 2);
      push_mem(T + 1 + k * P, 1'b0, a, 16'h0000);
      push_ack(T + 2 + L + k * P, k % 2, {8'hC0, a[7:0]});
    end
    fork
      seq3(0, 16'h0020);
      seq3(1, 16'h0030);
    join

    // Reset in the middle of WAIT: transaction dropped, prio back to 0.
    T = cyc;
    push_mem(T + 1, 1'b0, 16'h0010, 16'h0000);
    raise(0, 1'b0, 16'h0010, 16'h0000);
    tick(3);
    chk("busy_in_wait", 32'(busy), 32'd1);
    chk("owner_in_wait", 32'(owner), 32'd0);
    #2 reset = 1'b1;
    #1 chk_reset("midwait");
    req0 = 1'b0;
    tick(1);
    reset = 1'b0;
    tick(1);
    T = cyc;
    push_mem(T + 1, 1'b0, 16'h0001, 16'h0000);
    push_mem(T + 4 + L, 1'b0, 16'h0002, 16'h0000);
    push_ack(T + 2 + L, 0, 16'h1111);
    push_ack(T + 5 + 2 * L, 1, 16'h2222);
    fork
      txn(0, 1'b0, 16'h0001, 16'h0000);
      txn(1, 1'b0, 16'h0002, 16'h0000);
    join

    // halt rises during a thread 1 load; that load still completes, then the
    // pending thread 0 load waits until halt drops.
    T = cyc;
    push_mem(T + 1, 1'b0, 16'h0031, 16'h0000);
    push_ack(T + 2 + L, 1, 16'hC031);
    fork
      txn(1, 1'b0, 16'h0031, 16'h0000);
      begin
        tick(2);
        halt = 1'b1;
        raise(0, 1'b0, 16'h0021, 16'h0000);
      end
    join
    tick(4);
    chk("busy_halted", 32'(busy), 32'd0);
    H = cyc;
    push_mem(H + 1, 1'b0, 16'h0021, 16'h0000);
    push_ack(H + 2 + L, 0, 16'hC021);
    halt = 1'b0;
    wait_ack(0);

    tick(3);
    chk("mem_queue_drained", 32'(exp_mem.size()), 32'd0);
    chk("ack_queue_drained", 32'(exp_ack.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
